// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if -- serial line plus byte-strobe outputs of the UART receiver.
//   rx        : raw serial line (idles high), driven by the host side
//   rx_done   : one-cycle strobe, rx_data holds a freshly received byte
//   rx_data   : last correctly framed byte
//   frame_err : one-cycle strobe, stop bit low with non-zero data
//   break_det : one-cycle strobe, stop bit low with all-zero data
//   rx_busy   : high while a frame is in progress
// master = line driver / strobe consumer, slave = the receiver.
interface uart_byte_rx_if;
    logic       rx;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       break_det;
    logic       rx_busy;

    modport master (output rx, input rx_done, rx_data, frame_err, break_det, rx_busy);
    modport slave  (input rx, output rx_done, rx_data, frame_err, break_det, rx_busy);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx -- 16x oversampling 8N1 UART receiver (LSB first) with 3-sample
// majority vote, false-start rejection, framing-error and break reporting.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_byte_rx_if.slave (rx in; rx_done, rx_data, frame_err,
//           break_det, rx_busy out, all registered)
module uart_byte_rx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_byte_rx_if.slave bus
);
    localparam int CLKS_PER_TICK = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W         = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

    generate
        if (OVERSAMPLE != 16) begin : g_bad_os
            $error("uart_byte_rx: OVERSAMPLE must be 16");
        end
        if (CLKS_PER_TICK < 1) begin : g_bad_div
            $error("uart_byte_rx: CLK_FREQ_HZ too low for BAUD_RATE*16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       k_q, k_d;        // tick index 0..159 within the frame
    logic [1:0]       smp_q;           // samples taken at s=7 and s=8
    logic [7:0]       sh_q;
    logic [7:0]       data_q;
    logic             done_q, ferr_q, brk_q, busy_q;
    logic             sync1_q, rxs_q, rxsd_q;

    logic             tick, vote;
    logic [3:0]       smp_idx;

    assign tick    = (div_q == DIV_W'(CLKS_PER_TICK - 1));
    assign smp_idx = k_q[3:0];
    // Majority of s=7, s=8 and the live s=9 sample.
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        k_d   = k_q;
        if (tick) begin
            div_d = '0;
            k_d   = k_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            rxsd_q  <= 1'b1;
            state_q <= IDLE;
            div_q   <= '0;
            k_q     <= '0;
            smp_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= bus.rx;
            rxs_q   <= sync1_q;
            rxsd_q  <= rxs_q;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            if (state_q == IDLE) begin
                // Counters held clear so the first tick lands one full period after E.
                div_q <= '0;
                k_q   <= '0;
                if (!rxs_q && rxsd_q) begin
                    state_q <= START;
                    busy_q  <= 1'b1;
                end
            end else begin
                div_q <= div_d;
                k_q   <= k_d;
                if (tick) begin
                    if (smp_idx == 4'd7) smp_q[0] <= rxs_q;
                    if (smp_idx == 4'd8) smp_q[1] <= rxs_q;
                    case (state_q)
                        START: begin
                            if (smp_idx == 4'd9 && vote) begin
                                state_q <= IDLE;    // false start
                                busy_q  <= 1'b0;
                            end else if (smp_idx == 4'd15) begin
                                state_q <= DATA;
                            end
                        end
                        DATA: begin
                            if (smp_idx == 4'd9) sh_q <= {vote, sh_q[7:1]};
                            if (k_q == 8'd143) state_q <= STOP;
                        end
                        STOP: begin
                            // Decide mid stop bit; the tail is not waited out so
                            // back-to-back frames are caught.
                            if (smp_idx == 4'd9) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                if (vote) begin
                                    data_q <= sh_q;
                                    done_q <= 1'b1;
                                end else if (sh_q == 8'h00) begin
                                    brk_q <= 1'b1;
                                end else begin
                                    ferr_q <= 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.rx_done   = done_q;
    assign bus.rx_data   = data_q;
    assign bus.frame_err = ferr_q;
    assign bus.break_det = brk_q;
    assign bus.rx_busy   = busy_q;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx -- directed and randomized bench for uart_byte_rx.
// A line-history model derives every output cycle by cycle from the recorded
// pin values; directed literal checks pin the model to hand-computed cycles.
module tb_uart_byte_rx;
    localparam int CLK_HZ = 16_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int CPT    = CLK_HZ / (BAUD * 16);
    localparam int MAXC   = 100000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    uart_byte_rx_if bus();

    uart_byte_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    // Model state: pin and reset history, per cycle.
    bit   pin_h [MAXC];
    bit   rl_h  [MAXC];
    int   rel = 0;

    // Observations for directed checks.
    int         done_cyc [$];
    logic [7:0] done_dat [$];
    int         fe_cnt = 0, brk_cnt = 0, brk_cyc = 0;
    int         busy_rise = 0, busy_fall = 0;
    logic       pre_busy, post_busy;
    logic [7:0] post_data;

    // Synchronised line as seen by the receiver in cycle x: pin two cycles back,
    // or idle-high if that precedes the last reset release.
    function automatic bit rs(int x);
        if (x - 2 < rel || x - 2 < 1) return 1'b1;
        return pin_h[x-2];
    endfunction

    // Value of bit slot for a frame whose start edge was seen in cycle e.
    function automatic bit slot_val(int e, int slot);
        int ones = 0;
        for (int s = 7; s <= 9; s++) ones += int'(rs(e + (16*slot + s + 1) * CPT));
        return ones >= 2;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare process: advance model for this cycle, then check all outputs.
    initial begin : cmp
        int         c, d;
        bit         m_act, e_done, e_fe, e_brk, bprev;
        int         m_e;
        logic [7:0] m_data, val;
        logic [11:0] exp_v, act_v;
        m_act = 0; m_e = 0; m_data = 8'h00; bprev = 0;
        forever begin
            @(negedge clk);
            c = cyc;
            if (c >= MAXC) begin
                $display("FAIL cycle budget exceeded at %0d", c);
                $fatal(1);
            end
            pin_h[c] = bus.rx;
            rl_h[c]  = !rst_n;
            e_done = 0; e_fe = 0; e_brk = 0;
            if (rl_h[c]) begin
                m_act  = 0;
                m_data = 8'h00;
            end else if (rl_h[c-1]) begin
                rel = c;
            end else begin
                d = c - 1;
                if (!m_act) begin
                    if (!rs(d) && rs(d-1)) begin
                        m_act = 1;
                        m_e   = d;
                    end
                end else if (d == m_e + 10*CPT) begin
                    if (slot_val(m_e, 0)) m_act = 0;
                end else if (d == m_e + 154*CPT) begin
                    val = 8'h00;
                    for (int i = 0; i < 8; i++) val[i] = slot_val(m_e, i + 1);
                    if (slot_val(m_e, 9)) begin
                        e_done = 1;
                        m_data = val;
                    end else if (val == 8'h00) e_brk = 1;
                    else e_fe = 1;
                    m_act = 0;
                end
            end
            exp_v = {e_done, e_fe, e_brk, m_act, m_data};
            act_v = {bus.rx_done, bus.frame_err, bus.break_det, bus.rx_busy, bus.rx_data};
            checks++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL cycle %0d outputs: got done=%b fe=%b brk=%b busy=%b data=%02h expected done=%b fe=%b brk=%b busy=%b data=%02h",
                         c, act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                         exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
            checks++;
            if ($countones({bus.rx_done, bus.frame_err, bus.break_det}) > 1) begin
                fails++;
                $display("FAIL cycle %0d strobe exclusivity: got %b expected at most one", c,
                         {bus.rx_done, bus.frame_err, bus.break_det});
            end
            if (bus.rx_done === 1'b1) begin
                done_cyc.push_back(c);
                done_dat.push_back(bus.rx_data);
            end
            if (bus.frame_err === 1'b1) fe_cnt++;
            if (bus.break_det === 1'b1) begin
                brk_cnt++;
                brk_cyc = c;
            end
            if (bus.rx_busy === 1'b1 && !bprev) busy_rise = c;
            if (bus.rx_busy === 1'b0 && bprev) busy_fall = c;
            bprev = (bus.rx_busy === 1'b1);
        end
    end

    task automatic drive(input bit v);
        @(posedge clk);
        #1 bus.rx = v;
    endtask

    task automatic clear_obs();
        done_cyc.delete();
        done_dat.delete();
        fe_cnt = 0;
        brk_cnt = 0;
    endtask

    // One 8N1 frame; glitch inverts the pin at that clock offset, rst_on/rst_off
    // assert/release reset at those offsets (-1 = none). p = cycle of start edge.
    task automatic frame(input logic [7:0] d, input bit stop, input int glitch,
                         input int rst_on, input int rst_off, output int p);
        bit v;
        p = 0;
        for (int i = 0; i < 160; i++) begin
            if (i < 16) v = 1'b0;
            else if (i < 144) v = d[(i-16)/16];
            else v = stop;
            if (i == glitch) v = ~v;
            @(posedge clk);
            #1 bus.rx = v;
            if (i == 0) p = cyc;
            if (i == rst_on) begin
                pre_busy = bus.rx_busy;
                rst_n = 1'b0;
                #1;
                post_busy = bus.rx_busy;
                post_data = bus.rx_data;
            end
            if (i == rst_off) rst_n = 1'b1;
        end
    endtask

    logic [7:0] b2b [5] = '{8'hA1, 8'h00, 8'h00, 8'h10, 8'h00};

    initial begin : stim
        int p;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(bus.rx_busy), 0);
        chk("reset data", int'(bus.rx_data), 'h00);
        chk("reset strobes", int'({bus.rx_done, bus.frame_err, bus.break_det}), 0);
        rst_n = 1'b1;

        // Single byte with the pin edge in cycle 100.
        clear_obs();
        while (cyc < 99) drive(1'b1);
        frame(8'hA0, 1'b1, -1, -1, -1, p);
        repeat (20) drive(1'b1);
        chk("single done count", done_cyc.size(), 1);
        if (done_cyc.size() >= 1) begin
            chk("single done cycle", done_cyc[0], 257);
            chk("single data", int'(done_dat[0]), 'hA0);
        end
        chk("single busy rise", busy_rise, 103);
        chk("single busy fall", busy_fall, 257);

        // Back-to-back frames.
        clear_obs();
        for (int i = 0; i < 5; i++) frame(b2b[i], 1'b1, -1, -1, -1, p);
        repeat (20) drive(1'b1);
        chk("b2b done count", done_cyc.size(), 5);
        for (int i = 0; i < 5 && i < done_dat.size(); i++)
            chk($sformatf("b2b data %0d", i), int'(done_dat[i]), int'(b2b[i]));
        chk("b2b frame_err", fe_cnt, 0);

        // 5-clock glitch: false start only.
        clear_obs();
        drive(1'b0);
        p = cyc;
        repeat (4) drive(1'b0);
        repeat (30) drive(1'b1);
        chk("glitch strobes", done_cyc.size() + fe_cnt + brk_cnt, 0);
        chk("glitch busy rise", busy_rise - p, 3);
        chk("glitch busy fall", busy_fall - p, 13);
        frame(8'hC0, 1'b1, -1, -1, -1, p);
        repeat (20) drive(1'b1);
        chk("after glitch count", done_cyc.size(), 1);
        if (done_cyc.size() >= 1) chk("after glitch data", int'(done_dat[0]), 'hC0);
        // Single-clock low at s=8 of data bit 3.
        clear_obs();
        frame(8'hFF, 1'b1, 16*4 + 9, -1, -1, p);
        repeat (20) drive(1'b1);
        chk("vote count", done_cyc.size(), 1);
        if (done_cyc.size() >= 1) chk("vote data", int'(done_dat[0]), 'hFF);

        // Framing error, then a long low line.
        clear_obs();
        frame(8'h55, 1'b0, -1, -1, -1, p);
        repeat (640) drive(1'b0);
        chk("ferr count", fe_cnt, 1);
        chk("ferr no done", done_cyc.size() + brk_cnt, 0);
        chk("ferr data kept", int'(bus.rx_data), 'hFF);
        repeat (20) drive(1'b1);
        frame(8'h04, 1'b1, -1, -1, -1, p);
        repeat (20) drive(1'b1);
        chk("after ferr count", done_cyc.size(), 1);
        if (done_cyc.size() >= 1) chk("after ferr data", int'(done_dat[0]), 'h04);

        // Break: line low 20 bit times.
        clear_obs();
        drive(1'b0);
        p = cyc;
        repeat (319) drive(1'b0);
        repeat (30) drive(1'b1);
        chk("break count", brk_cnt, 1);
        chk("break cycle", brk_cyc - p, 157);
        chk("break others", done_cyc.size() + fe_cnt, 0);

        // Reset during data bit 4, released in the stop bit.
        clear_obs();
        frame(8'h3C, 1'b1, -1, 16*5 + 4, 16*9 + 4, p);
        repeat (20) drive(1'b1);
        chk("rst pre busy", int'(pre_busy), 1);
        chk("rst async busy", int'(post_busy), 0);
        chk("rst async data", int'(post_data), 'h00);
        chk("rst no strobes", done_cyc.size() + fe_cnt + brk_cnt, 0);
        frame(8'h02, 1'b1, -1, -1, -1, p);
        repeat (20) drive(1'b1);
        chk("after rst count", done_cyc.size(), 1);
        if (done_cyc.size() >= 1) chk("after rst data", int'(done_dat[0]), 'h02);

        // Random traffic: gaps, bad stops, zero bytes, glitches, short pulses.
        for (int n = 0; n < 150; n++) begin
            int         gap, kind, gl;
            logic [7:0] b;
            gap = $urandom_range(0, 24);
            repeat (gap) drive(1'b1);
            kind = $urandom_range(0, 15);
            if (kind == 0) begin
                repeat ($urandom_range(1, 12)) drive(1'b0);
            end else begin
                b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                gl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 159)) : -1;
                frame(b, $urandom_range(0, 7) != 0, gl, -1, -1, p);
            end
        end
        repeat (200) drive(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
